data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//  Memory-side responder to the decoder's load/store controls (memWrite_en, addrSelect, ResultSrc).
//  Turns one CPU byte or word access into byte beats on a byte-wide RAM port that uses a req/ack handshake.
//  Stalls the CPU until the access completes. Sits between the execute stage and data RAM.
// PARAMETERS
//  MEM_AW    17  byte-address width of the RAM port; CPU address bits above this are ignored
//  XLEN      32  CPU data and address width; fixed at 32, word = 4 beats
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst_n          in   1       reset; asynchronous, active-low
//  req_valid_i    in   1       CPU load/store present; CPU holds all req inputs stable while stall_o=1
//  memWrite_en_i  in   1       1 = store, 0 = load
//  addrSelect_i   in   1       0 = byte (lb/sb), 1 = word (lw/sw)
//  addr_i         in   XLEN    byte address (ALU result)
//  wdata_i        in   XLEN    store data; sb uses [7:0]
//  stall_o        out  1       freeze PC/pipeline
//  rdata_o        out  XLEN    load result; holds until next load completes
//  rdata_valid_o  out  1       1-cycle pulse when rdata_o is updated
//  misaligned_o   out  1       1-cycle pulse: word access with addr_i[1:0] != 0, access dropped
//  mem_req_o      out  1       beat request; held with addr/we/wdata until mem_ack_i
//  mem_we_o       out  1       beat is a write
//  mem_addr_o     out  MEM_AW  beat byte address
//  mem_wdata_o    out  8       beat write byte
//  mem_ack_i      in   1       beat complete this cycle; mem_rdata_i valid for reads
//  mem_rdata_i    in   8       read byte
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, beat count 0, rdata_o=0; every output 0.
//  FSM states: IDLE, ACCESS, DONE.
//  IDLE: on req_valid_i, when the access is word and addr_i[1:0]!=0:
//   - misaligned_o=1 that cycle; stall_o=0; no state change; no mem_req_o.
//  IDLE: on any other req_valid_i:
//   - stall_o=1 combinationally in that same cycle.
//   - Capture addr[MEM_AW-1:0], wdata, we, size; set beat count 0; go to ACCESS.
//  ACCESS:
//   - mem_req_o=1, stall_o=1, mem_addr_o = captured addr + beat (mod 2^MEM_AW).
//   - mem_we_o = we; mem_wdata_o = wdata byte lane [beat] (little-endian).
//   - On mem_ack_i: on a read, store mem_rdata_i into byte lane [beat] of an assembly register.
//   - After the ack, if beat = last (0 for byte, 3 for word), go to DONE; otherwise beat+1.
//   - The next beat's request starts the cycle after the ack. No back-to-back beat in the ack cycle.
//   - Without ack, req, addr, we and wdata stay stable indefinitely. No timeout.
//  DONE (exactly 1 cycle):
//   - stall_o=0; mem_req_o=0. The CPU advances at the end of this cycle.
//   - On a load: rdata_valid_o=1 and rdata_o updates. lb result is sign-extended from byte bit 7; lw result is the assembled word.
//   - req_valid_i is ignored in DONE (it is the same retiring request). Next state IDLE.
//  Latency with ack every cycle:
//   - Byte access: stall_o high for 2 cycles.
//   - Word access: stall_o high for 5 cycles.
//   - Result is visible in the DONE cycle.
//  Store: rdata_o is unchanged and rdata_valid_o stays 0.
//  Reset mid-access aborts at once: mem_req_o drops asynchronously. Bytes already written stay in RAM.
//  Address wrap: a word at (2^MEM_AW)-2 is misaligned. Wrap can only occur via the ignored upper address bits.
// TESTING
//  1. sw 0xDEADBEEF @0x100, ack every cycle -> 4 write beats EF,BE,AD,DE @0x100..0x103; stall_o high 5 cycles.
//  2. Then lb @0x103 -> one read beat @0x103; rdata_o=0xFFFFFFDE; rdata_valid_o pulses in the DONE cycle.
//  3. lw @0x100 with ack delayed 3 cycles on beat 2 -> mem_req_o/mem_addr_o=0x102 held 4 cycles; rdata_o=0xDEADBEEF.
//  4. lw @0x102 -> misaligned_o pulses 1 cycle; stall_o=0; mem_req_o never rises; rdata_o unchanged.
//  5. sw 0x11223344 @0x200, rst_n low after beat 1 ack -> mem_req_o low immediately; outputs 0; only 0x200=44, 0x201=33 written.
//  6. sb 0xA5 @0x3 then lb @0x3 -> single beat each; rdata_o=0xFFFFFFA5; stall_o high 2 cycles per access.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: turns CPU byte/word loads and stores into byte beats on a req/ack RAM port, stalling the CPU until done
module data_mem_ctrl #(
  parameter int MEM_AW = 17,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic              memWrite_en_i,
  input  logic              addrSelect_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              rdata_valid_o,
  output logic              misaligned_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_beat;
  logic [MEM_AW-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_asm;
  logic [XLEN-1:0]   r_rdata;
  logic              r_we;
  logic              r_size;

  logic              w_req;
  logic              w_mis;
  logic              w_start;
  logic              w_access;
  logic              w_load_done;
  logic              w_last;
  logic [XLEN-1:0]   w_result;

  // reset also masks the combinational request path so every output reads 0 while held in reset
  assign w_req       = req_valid_i & rst_n & (r_state == S_IDLE);
  assign w_mis       = w_req & addrSelect_i & (addr_i[1:0] != 2'b00);
  assign w_start     = w_req & ~w_mis;
  assign w_access    = (r_state == S_ACCESS);
  assign w_load_done = (r_state == S_DONE) & ~r_we;
  assign w_last      = r_size ? (r_beat == 2'd3) : 1'b1;
  assign w_result    = r_size ? r_asm : {{(XLEN-8){r_asm[7]}}, r_asm[7:0]};

  assign misaligned_o  = w_mis;
  assign stall_o       = w_start | w_access;
  assign mem_req_o     = w_access;
  assign mem_we_o      = w_access & r_we;
  assign mem_addr_o    = w_access ? r_addr + MEM_AW'(r_beat) : '0;
  assign mem_wdata_o   = w_access ? r_wdata[{r_beat, 3'b000} +: 8] : 8'h00;
  assign rdata_valid_o = w_load_done;
  assign rdata_o       = w_load_done ? w_result : r_rdata;

  // access sequencer: capture request, walk the beats, retire in a single DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_asm   <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_size  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_start) begin
        r_state <= S_ACCESS;
        r_beat  <= 2'd0;
        r_addr  <= addr_i[MEM_AW-1:0];
        r_wdata <= wdata_i;
        r_we    <= memWrite_en_i;
        r_size  <= addrSelect_i;
      end
    end else if (r_state == S_ACCESS) begin
      if (mem_ack_i) begin
        if (!r_we) r_asm[{r_beat, 3'b000} +: 8] <= mem_rdata_i;
        if (w_last) r_state <= S_DONE;
        else r_beat <= r_beat + 2'd1;
      end
    end else begin
      if (!r_we) r_rdata <= w_result;
      r_state <= S_IDLE;
    end
  end
endmodule
